// File: rtl/mux2x1_rr_arbiter_if.sv
// Bus between two requesters and the shared 2:1 mux arbiter.
// The requester side drives req/data; the arbiter returns grants, select and the muxed word.
interface mux2x1_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] a1;
    logic             gnt0;
    logic             gnt1;
    logic             s;
    logic [WIDTH-1:0] y;
    logic             y_valid;

    modport master (
        output req0, req1, a0, a1,
        input  gnt0, gnt1, s, y, y_valid
    );

    modport slave (
        input  req0, req1, a0, a1,
        output gnt0, gnt1, s, y, y_valid
    );
endinterface

// File: rtl/mux2x1_rr_arbiter.sv
// Round-robin arbiter with bounded grant hold, driving a shared 2:1 mux.
// Grants and select are registered; the muxed word y is combinational from s.
module mux2x1_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux2x1_rr_arbiter_if.slave   bus
);
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE, G0, G1} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_q, last_d;
    logic            s_q, s_d;
    logic [WIDTH-1:0] y_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            s_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            s_q     <= s_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.req0 && bus.req1) state_d = last_q ? G0 : G1;
                else if (bus.req0)        state_d = G0;
                else if (bus.req1)        state_d = G1;
            end
            G0: begin
                if (!bus.req0 || cnt_q == LIMIT) begin
                    cnt_d = '0;
                    if (bus.req1) begin
                        state_d = G1;
                        last_d  = 1'b0;
                    end else if (!bus.req0) begin
                        state_d = IDLE;
                        last_d  = 1'b0;
                    end
                    // else: hold limit hit with no contender, restart the run in G0
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            G1: begin
                if (!bus.req1 || cnt_q == LIMIT) begin
                    cnt_d = '0;
                    if (bus.req0) begin
                        state_d = G0;
                        last_d  = 1'b1;
                    end else if (!bus.req1) begin
                        state_d = IDLE;
                        last_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Select follows the next grant; IDLE leaves the mux where it was
        case (state_d)
            G0:      s_d = 1'b0;
            G1:      s_d = 1'b1;
            default: s_d = s_q;
        endcase
    end

    assign y_w         = s_q ? bus.a1 : bus.a0;
    assign bus.gnt0    = (state_q == G0);
    assign bus.gnt1    = (state_q == G1);
    assign bus.s       = s_q;
    assign bus.y       = y_w;
    assign bus.y_valid = (state_q == G0) || (state_q == G1);
endmodule

// File: tb/tb_mux2x1_rr_arbiter.sv
// Bench for mux2x1_rr_arbiter: vector table with a scoreboard queue, plus an async-reset sequence.
// Two instances: MAX_HOLD=4 (sel=0) and MAX_HOLD=1 (sel=1).
module tb_mux2x1_rr_arbiter;
    logic clk;
    logic rst_n;

    mux2x1_rr_arbiter_if #(.WIDTH(8)) bus4 ();
    mux2x1_rr_arbiter_if #(.WIDTH(8)) bus1 ();

    mux2x1_rr_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    mux2x1_rr_arbiter #(.WIDTH(8), .MAX_HOLD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp packs {gnt0, gnt1, s, y_valid, y}
    typedef struct {
        bit         sel;
        bit         rstn;
        bit         r0;
        bit         r1;
        logic [7:0] a0;
        logic [7:0] a1;
        logic [11:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [11:0] sb_q[$];
    int          total = 0;
    int          bad   = 0;

    function automatic vec_t mk(bit sel, bit rstn, bit r0, bit r1, logic [7:0] a0, logic [7:0] a1,
                                bit g0, bit g1, bit s, bit v, logic [7:0] y);
        vec_t t;
        t.sel  = sel;
        t.rstn = rstn;
        t.r0   = r0;
        t.r1   = r1;
        t.a0   = a0;
        t.a1   = a1;
        t.exp  = {g0, g1, s, v, y};
        return t;
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] observe(bit sel);
        if (sel) return {bus1.gnt0, bus1.gnt1, bus1.s, bus1.y_valid, bus1.y};
        return {bus4.gnt0, bus4.gnt1, bus4.s, bus4.y_valid, bus4.y};
    endfunction

    initial begin
        bit g0;
        logic [11:0] exp;
        rst_n = 1'b0;
        bus4.req0 = 1'b0; bus4.req1 = 1'b0; bus4.a0 = '0; bus4.a1 = '0;
        bus1.req0 = 1'b0; bus1.req1 = 1'b0; bus1.a0 = '0; bus1.a1 = '0;

        // Reset with both requesting, then contention in runs of four
        tbl.push_back(mk(0, 0, 1, 1, 8'h11, 8'h22, 0, 0, 0, 0, 8'h11));
        tbl.push_back(mk(0, 0, 1, 1, 8'h11, 8'h22, 0, 0, 0, 0, 8'h11));
        for (int i = 0; i < 16; i++) begin
            g0 = ((i / 4) % 2) == 0;
            tbl.push_back(mk(0, 1, 1, 1, 8'h11, 8'h22, g0, !g0, !g0, 1, g0 ? 8'h11 : 8'h22));
        end
        // Solo requester 1 keeps its grant past the hold limit
        tbl.push_back(mk(0, 0, 0, 1, 8'h00, 8'hA5, 0, 0, 0, 0, 8'h00));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(0, 1, 0, 1, 8'h00, 8'hA5, 0, 1, 1, 1, 8'hA5));
        // Early drops, IDLE keeping s, and the tie going to the not-last-served side
        tbl.push_back(mk(0, 0, 0, 0, 8'h3C, 8'hC3, 0, 0, 0, 0, 8'h3C));
        tbl.push_back(mk(0, 1, 1, 0, 8'h3C, 8'hC3, 1, 0, 0, 1, 8'h3C));
        tbl.push_back(mk(0, 1, 1, 0, 8'h3C, 8'hC3, 1, 0, 0, 1, 8'h3C));
        tbl.push_back(mk(0, 1, 0, 1, 8'h3C, 8'hC3, 0, 1, 1, 1, 8'hC3));
        tbl.push_back(mk(0, 1, 0, 0, 8'h3C, 8'hC3, 0, 0, 1, 0, 8'hC3));
        tbl.push_back(mk(0, 1, 1, 0, 8'h3C, 8'hC3, 1, 0, 0, 1, 8'h3C));
        tbl.push_back(mk(0, 1, 1, 0, 8'h3C, 8'hC3, 1, 0, 0, 1, 8'h3C));
        tbl.push_back(mk(0, 1, 0, 0, 8'h3C, 8'hC3, 0, 0, 0, 0, 8'h3C));
        tbl.push_back(mk(0, 1, 1, 1, 8'h3C, 8'hC3, 0, 1, 1, 1, 8'hC3));
        // MAX_HOLD=1 instance alternates every cycle
        tbl.push_back(mk(1, 0, 1, 1, 8'h11, 8'h22, 0, 0, 0, 0, 8'h11));
        for (int i = 0; i < 8; i++) begin
            g0 = (i % 2) == 0;
            tbl.push_back(mk(1, 1, 1, 1, 8'h11, 8'h22, g0, !g0, !g0, 1, g0 ? 8'h11 : 8'h22));
        end

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst_n = tbl[i].rstn;
            if (tbl[i].sel) begin
                bus1.req0 = tbl[i].r0; bus1.req1 = tbl[i].r1;
                bus1.a0 = tbl[i].a0;   bus1.a1 = tbl[i].a1;
            end else begin
                bus4.req0 = tbl[i].r0; bus4.req1 = tbl[i].r1;
                bus4.a0 = tbl[i].a0;   bus4.a1 = tbl[i].a1;
            end
            sb_q.push_back(tbl[i].exp);
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard_empty at vec %0d", i);
            end else begin
                exp = sb_q.pop_front();
                check($sformatf("vec%0d", i), observe(tbl[i].sel), exp);
            end
        end

        // Async reset while requester 1 holds the grant
        bus1.req0 = 1'b0; bus1.req1 = 1'b0;
        @(negedge clk);
        bus4.req0 = 1'b0; bus4.req1 = 1'b1; bus4.a0 = 8'h66; bus4.a1 = 8'h5A;
        @(posedge clk);
        #1;
        check("async_pre_gnt1", {11'd0, bus4.gnt1}, 12'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_gnt1", {11'd0, bus4.gnt1}, 12'd0);
        check("async_s", {11'd0, bus4.s}, 12'd0);
        check("async_valid", {11'd0, bus4.y_valid}, 12'd0);
        check("async_y", {4'd0, bus4.y}, 12'h066);
        bus4.req0 = 1'b1; bus4.req1 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_g0", {10'd0, bus4.gnt0, bus4.gnt1}, 12'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
